// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshake and sticky overflow.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier (opcode 1000).
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             overflow,
   output logic             negative,
   output logic             sticky_ovf,
   input  logic             clr_sticky
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b0111;
   localparam logic [3:0] OP_SRA = 4'b1001;
   localparam logic [3:0] OP_ROL = 4'b1010;
   localparam logic [3:0] OP_ROR = 4'b1011;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   logic             slot_free;
   logic             load_alu;
   logic             ld;
   logic [WIDTH-1:0] ld_res;
   logic             ld_c;
   logic             ld_v;

   assign slot_free = !out_valid || out_ready;

   // Single-cycle operations; MUL and reserved codes fall to the default.
   always_comb begin
      sum     = {1'b0, A} + {1'b0, B};
      diff    = {1'b0, A} - {1'b0, B};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      unique case (opcode)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                      (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                      (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_NOT: alu_res = ~A;
         OP_SHL: begin
            alu_res = {A[WIDTH-2:0], 1'b0};
            alu_c   = A[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, A[WIDTH-1:1]};
            alu_c   = A[0];
         end
         OP_SRA: begin
            alu_res = {A[WIDTH-1], A[WIDTH-1:1]};
            alu_c   = A[0];
         end
         OP_ROL: begin
            alu_res = {A[WIDTH-2:0], A[WIDTH-1]};
            alu_c   = A[WIDTH-1];
         end
         OP_ROR: begin
            alu_res = {A[0], A[WIDTH-1:1]};
            alu_c   = A[0];
         end
         default: begin
            alu_res = '0;
            alu_c   = 1'b0;
            alu_v   = 1'b0;
         end
      endcase
   end

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam int         CNT_W  = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      MUL_RUN
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic               start_mul;
   logic               mul_step;
   logic               load_mul;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      load_alu  = 1'b0;
      start_mul = 1'b0;
      mul_step  = 1'b0;
      load_mul  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = slot_free;
            if (in_valid && slot_free) begin
               if (opcode == OP_MUL) begin
                  start_mul = 1'b1;
                  state_nxt = MUL_RUN;
               end else begin
                  load_alu = 1'b1;
               end
            end
         end
         MUL_RUN: begin
            if (count != '0) begin
               mul_step = 1'b1;
            end else if (slot_free) begin
               load_mul  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One multiplier bit per cycle, LSB first, into a double-width accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start_mul) begin
         count  <= CNT_W'(WIDTH);
         mcand  <= {{WIDTH{1'b0}}, A};
         mplier <= B;
         acc    <= '0;
      end else if (mul_step) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - 1'b1;
      end
   end

   assign ld     = load_alu | load_mul;
   assign ld_res = load_mul ? acc[WIDTH-1:0] : alu_res;
   assign ld_c   = load_mul ? |acc[2*WIDTH-1:WIDTH] : alu_c;
   assign ld_v   = load_mul ? |acc[2*WIDTH-1:WIDTH] : alu_v;
`else
   always_comb begin
      in_ready = slot_free;
      load_alu = in_valid && slot_free;
   end

   assign ld     = load_alu;
   assign ld_res = alu_res;
   assign ld_c   = alu_c;
   assign ld_v   = alu_v;
`endif

   // zero is registered rather than decoded so that it reads 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         result     <= '0;
         carry      <= 1'b0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
         negative   <= 1'b0;
         sticky_ovf <= 1'b0;
      end else begin
         if (ld) begin
            out_valid <= 1'b1;
            result    <= ld_res;
            carry     <= ld_c;
            overflow  <= ld_v;
            zero      <= (ld_res == '0);
            negative  <= ld_res[WIDTH-1];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (ld && ld_v)      sticky_ovf <= 1'b1;
         else if (clr_sticky) sticky_ovf <= 1'b0;
      end
   end

endmodule
